clasificador_pulsacion: RTL and testbench

CLASIFICADOR_PULSACION -- requirements
Module: clasificador_pulsacion

---
 rtl/clasificador_pulsacion.sv | 108 ++++++++++
 tb/tb_clasificador_pulsacion.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/clasificador_pulsacion.sv
// Button-press classifier: turns a debounced button level into short-press,
// long-press and auto-repeat strobes, and keeps a running count of short presses.
module clasificador_pulsacion #(
  parameter int T_LARGO = 50000000,
  parameter int T_REP   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       pulso_corto,
  output logic       pulso_largo,
  output logic       pulso_rep,
  output logic       presionado,
  output logic [7:0] num_cortos,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    PRESIONADO = 2'd1,
    REPITIENDO = 2'd2,
    INVALIDO   = 2'd3
  } estado_t;

  localparam logic [26:0] C_LARGO = 27'(T_LARGO);
  localparam logic [26:0] C_REP   = 27'(T_REP);

  estado_t     r_est;
  logic [25:0] r_cnt;
  logic        r_corto;
  logic        r_largo;
  logic        r_rep;
  logic        r_pres;
  logic [7:0]  r_num;
  logic [26:0] w_cnt_inc;

  // One extra bit so cnt+1 never wraps before the compare.
  assign w_cnt_inc = {1'b0, r_cnt} + 27'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_est   <= REPOSO;
      r_cnt   <= '0;
      r_corto <= 1'b0;
      r_largo <= 1'b0;
      r_rep   <= 1'b0;
      r_pres  <= 1'b0;
      r_num   <= '0;
    end else begin
      r_corto <= 1'b0;
      r_largo <= 1'b0;
      r_rep   <= 1'b0;
      case (r_est)
        REPOSO: begin
          if (btn_in) begin
            r_est  <= PRESIONADO;
            r_cnt  <= 26'd1;
            r_pres <= 1'b1;
          end else begin
            r_cnt  <= '0;
            r_pres <= 1'b0;
          end
        end
        PRESIONADO: begin
          if (!btn_in) begin
            r_est   <= REPOSO;
            r_cnt   <= '0;
            r_corto <= 1'b1;
            r_num   <= r_num + 8'd1;
            r_pres  <= 1'b0;
          end else if (w_cnt_inc == C_LARGO) begin
            r_est   <= REPITIENDO;
            r_cnt   <= '0;
            r_largo <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc[25:0];
          end
        end
        REPITIENDO: begin
          if (!btn_in) begin
            // Releasing a long press is silent: no short-press strobe or count.
            r_est  <= REPOSO;
            r_cnt  <= '0;
            r_pres <= 1'b0;
          end else if (w_cnt_inc == C_REP) begin
            r_cnt <= '0;
            r_rep <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc[25:0];
          end
        end
        default: begin
          r_est  <= REPOSO;
          r_cnt  <= '0;
          r_pres <= 1'b0;
        end
      endcase
    end
  end

  assign pulso_corto = r_corto;
  assign pulso_largo = r_largo;
  assign pulso_rep   = r_rep;
  assign presionado  = r_pres;
  assign num_cortos  = r_num;
  assign estado      = r_est;

endmodule

// File: tb/tb_clasificador_pulsacion.sv
// Scoreboard bench for clasificador_pulsacion: a press-length reference model
// predicts every cycle's outputs; a monitor pops and compares after each edge.
module tb_clasificador_pulsacion;

  localparam int TL = 8;
  localparam int TR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       pulso_corto, pulso_largo, pulso_rep, presionado;
  logic [7:0] num_cortos;
  logic [1:0] estado;

  clasificador_pulsacion #(.T_LARGO(TL), .T_REP(TR)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .pulso_corto(pulso_corto), .pulso_largo(pulso_largo), .pulso_rep(pulso_rep),
    .presionado(presionado), .num_cortos(num_cortos), .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       corto;
    logic       largo;
    logic       rep;
    logic       pres;
    logic [7:0] nc;
    logic [1:0] est;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   corto_seen = 0;

  // Reference model: only the length of the current run of high samples matters.
  int run = 0;
  int ncort = 0;

  task automatic step(input logic b, input logic r = 1'b0);
    exp_t e;
    @(negedge clk);
    btn_in = b;
    rst    = r;
    e = '0;
    if (r) begin
      run = 0;
      ncort = 0;
    end else if (b) begin
      run++;
      e.largo = (run == TL);
      e.rep   = (run > TL) && ((run - TL) % TR == 0);
      e.pres  = 1'b1;
      e.est   = (run < TL) ? 2'd1 : 2'd2;
    end else begin
      if (run >= 1 && run < TL) begin
        e.corto = 1'b1;
        ncort = (ncort + 1) % 256;
      end
      run = 0;
    end
    e.nc = 8'(ncort);
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1);
    for (int i = 0; i < lo; i++) step(1'b0);
  endtask

  exp_t       m_exp;
  exp_t       m_act;
  logic [2:0] m_prev = '0;
  logic [2:0] m_cur;

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_exp = q.pop_front();
      m_act = '{pulso_corto, pulso_largo, pulso_rep, presionado, num_cortos, estado};
      vectors++;
      if (m_act !== m_exp) begin
        miscompares++;
        $display("FAIL outputs t=%0t actual c/l/r/p/nc/est=%b/%b/%b/%b/%0d/%0d required %b/%b/%b/%b/%0d/%0d",
                 $time, m_act.corto, m_act.largo, m_act.rep, m_act.pres, m_act.nc, m_act.est,
                 m_exp.corto, m_exp.largo, m_exp.rep, m_exp.pres, m_exp.nc, m_exp.est);
      end
      m_cur = {pulso_corto, pulso_largo, pulso_rep};
      vectors++;
      if (!$onehot0(m_cur) || ((m_cur & m_prev) != 3'b000)) begin
        miscompares++;
        $display("FAIL strobes t=%0t actual now=%b prev=%b required onehot0, no repeat", $time, m_cur, m_prev);
      end
      m_prev = m_cur;
      if (pulso_corto === 1'b1) corto_seen++;
    end
  end

  int   c0;
  logic [7:0] nc0;

  initial begin
    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0);

    // Short press, then the 7/8 boundary
    press(3, 3);
    press(TL - 1, 3);
    press(TL, 3);
    press(1, 2);

    // Auto-repeat: hold 20 cycles then release
    press(20, 4);

    // Wrap: 256 short presses bring the counter back around
    #2;
    c0  = corto_seen;
    nc0 = num_cortos;
    for (int i = 0; i < 256; i++) press(1 + (i % (TL - 1)), 1);
    step(1'b0);
    #2;
    vectors++;
    if (corto_seen - c0 != 256 || num_cortos !== nc0) begin
      miscompares++;
      $display("FAIL wrap actual strobes=%0d nc=%0d required strobes=256 nc=%0d",
               corto_seen - c0, num_cortos, nc0);
    end

    // Randomized press lengths
    for (int i = 0; i < 150; i++) press($urandom_range(1, 22), $urandom_range(1, 3));

    // Async reset in the middle of auto-repeat, button still held at release
    press(TL + 6, 0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({pulso_corto, pulso_largo, pulso_rep, presionado, num_cortos, estado} !== 14'd0) begin
      miscompares++;
      $display("FAIL async_reset actual c/l/r/p/nc/est=%b/%b/%b/%b/%0d/%0d required all 0",
               pulso_corto, pulso_largo, pulso_rep, presionado, num_cortos, estado);
    end
    step(1'b1, 1'b1);
    press(TL + 5, 3);
    press(2, 2);

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain actual %0d pending required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
